mcs_bus_bridge: RTL and testbench



---
 rtl/mcs_bus_bridge.sv | 140 ++++++++++++++
 tb/tb_mcs_bus_bridge.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs_bus_bridge.sv
// MicroBlaze MCS IO-bus to multi-slot system-bus bridge.
// Decodes a window and slot, runs one cycle per access with ack/timeout, and reports errors.
module mcs_bus_bridge #(
  parameter logic [31:0] BRIDGE_BASE = 32'hC000_0000,
  parameter int unsigned N_SLOTS     = 2,
  parameter int unsigned ADDR_W      = 21,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  io_addr_strobe,
  input  logic                  io_read_strobe,
  input  logic                  io_write_strobe,
  input  logic [31:0]           io_address,
  input  logic [3:0]            io_byte_enable,
  input  logic [31:0]           io_write_data,
  output logic [31:0]           io_read_data,
  output logic                  io_ready,
  output logic [N_SLOTS-1:0]    sys_cs,
  output logic                  sys_rd,
  output logic                  sys_wr,
  output logic [ADDR_W-1:0]     sys_addr,
  output logic [3:0]            sys_be,
  output logic [31:0]           sys_wr_data,
  input  logic [32*N_SLOTS-1:0] sys_rd_data,
  input  logic [N_SLOTS-1:0]    sys_ack,
  output logic                  bus_err,
  output logic [7:0]            err_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic              req;
  logic [1:0]        req_slot;
  logic              win_hit;
  logic [N_SLOTS-1:0] cs_dec;
  logic [31:0]       sel_rd_data;
  logic              ack_sel;
  logic              tmo_hit;
  logic              err_event;
  logic [TW-1:0]     tmo_cnt;
  logic              is_wr_q;
  logic              err_q;
  logic [31:0]       rd_data_q;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^io_address;

  assign req      = io_addr_strobe & (io_read_strobe | io_write_strobe);
  assign req_slot = io_address[23:22];
  assign win_hit  = (io_address[31:24] == BRIDGE_BASE[31:24]) &&
                    ({1'b0, req_slot} < 3'(N_SLOTS));

  // sys_cs is one-hot during ACCESS, so it doubles as the latched slot select.
  always_comb begin
    cs_dec      = '0;
    sel_rd_data = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      cs_dec[i] = (req_slot == 2'(i));
      if (sys_cs[i]) sel_rd_data = sel_rd_data | sys_rd_data[32*i +: 32];
    end
  end

  assign ack_sel = |(sys_ack & sys_cs);
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = win_hit ? ACCESS : RESP;
      ACCESS:  if (ack_sel || tmo_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    io_ready     = (state_q == RESP);
    bus_err      = (state_q == RESP) && err_q;
    io_read_data = '0;
    if (state_q == RESP && !is_wr_q) io_read_data = err_q ? ERR_DATA : rd_data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sys_cs      <= '0;
      sys_rd      <= 1'b0;
      sys_wr      <= 1'b0;
      sys_addr    <= '0;
      sys_be      <= '0;
      sys_wr_data <= '0;
      is_wr_q     <= 1'b0;
      err_q       <= 1'b0;
      rd_data_q   <= '0;
      tmo_cnt     <= '0;
    end else if (state_q == IDLE && req) begin
      sys_addr    <= io_address[ADDR_W+1:2];
      sys_be      <= io_byte_enable;
      sys_wr_data <= io_write_data;
      is_wr_q     <= io_write_strobe;
      err_q       <= !win_hit;
      tmo_cnt     <= '0;
      if (win_hit) begin
        sys_cs <= cs_dec;
        sys_rd <= !io_write_strobe;
        sys_wr <= io_write_strobe;
      end
    end else if (state_q == ACCESS) begin
      if (ack_sel || tmo_hit) begin
        if (ack_sel && sys_rd) rd_data_q <= sel_rd_data;
        err_q  <= !ack_sel;
        sys_cs <= '0;
        sys_rd <= 1'b0;
        sys_wr <= 1'b0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  // Counted on entry to RESP so the new value is visible alongside bus_err.
  assign err_event = (state_q == IDLE && req && !win_hit) ||
                     (state_q == ACCESS && !ack_sel && tmo_hit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         err_cnt <= '0;
    else if (err_event && err_cnt != '1)  err_cnt <= err_cnt + 1'b1;
  end

endmodule

// File: tb/tb_mcs_bus_bridge.sv
// Self-checking bench for mcs_bus_bridge: scoreboard of expected responses per access.
module tb_mcs_bus_bridge;
  localparam int unsigned N_SLOTS     = 2;
  localparam int unsigned ADDR_W      = 21;
  localparam int unsigned TIMEOUT_CYC = 64;
  localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset_n;
  logic io_addr_strobe, io_read_strobe, io_write_strobe;
  logic [31:0] io_address, io_write_data, io_read_data;
  logic [3:0]  io_byte_enable;
  logic        io_ready;
  logic [N_SLOTS-1:0] sys_cs, sys_ack, ack_manual;
  logic        ack_follow;
  logic        sys_rd, sys_wr;
  logic [ADDR_W-1:0] sys_addr;
  logic [3:0]  sys_be;
  logic [31:0] sys_wr_data;
  logic [32*N_SLOTS-1:0] sys_rd_data;
  logic        bus_err;
  logic [7:0]  err_cnt;

  mcs_bus_bridge #(
    .BRIDGE_BASE(32'hC000_0000), .N_SLOTS(N_SLOTS), .ADDR_W(ADDR_W),
    .TIMEOUT_CYC(TIMEOUT_CYC), .ERR_DATA(ERR_DATA)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
    .io_write_strobe(io_write_strobe), .io_address(io_address),
    .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .io_ready(io_ready),
    .sys_cs(sys_cs), .sys_rd(sys_rd), .sys_wr(sys_wr), .sys_addr(sys_addr),
    .sys_be(sys_be), .sys_wr_data(sys_wr_data), .sys_rd_data(sys_rd_data),
    .sys_ack(sys_ack), .bus_err(bus_err), .err_cnt(err_cnt)
  );

  assign sys_ack = ack_follow ? sys_cs : ack_manual;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic err; int lat; } exp_t;
  exp_t sb[$];
  exp_t e;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  int                obs_lat, obs_cs_cyc, obs_wr_cyc;
  logic [31:0]       obs_data, obs_wdata1;
  logic              obs_err, obs_rd1, obs_wr1;
  logic [7:0]        obs_cnt;
  logic [N_SLOTS-1:0] obs_cs1;
  logic [ADDR_W-1:0] obs_addr1;
  logic [3:0]        obs_be1;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return w[ADDR_W-1:0];
  endfunction

  function automatic int bump(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  // ack_at: 0 = ack follows cs, -1 = never, k = ack mask driven in ACCESS cycle k.
  task automatic issue(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata,
                       input logic rd, input logic wr, input int ack_at,
                       input logic [N_SLOTS-1:0] mask, input logic [31:0] ack_data,
                       input int poke_at);
    int cyc;
    for (int i = 0; i < N_SLOTS; i++) sys_rd_data[32*i +: 32] = mask[i] ? ack_data : ~ack_data;
    ack_follow = (ack_at == 0);
    ack_manual = '0;
    @(negedge clk);
    io_address = addr; io_byte_enable = be; io_write_data = wdata;
    io_addr_strobe = 1'b1; io_read_strobe = rd; io_write_strobe = wr;
    @(negedge clk);
    {io_addr_strobe, io_read_strobe, io_write_strobe} = '0;
    obs_lat = -1; obs_cs_cyc = 0; obs_wr_cyc = 0;
    obs_cs1 = sys_cs; obs_rd1 = sys_rd; obs_wr1 = sys_wr;
    obs_addr1 = sys_addr; obs_be1 = sys_be; obs_wdata1 = sys_wr_data;
    for (cyc = 1; cyc <= int'(TIMEOUT_CYC) + 8; cyc++) begin
      if (sys_cs != '0) obs_cs_cyc++;
      if (sys_wr) obs_wr_cyc++;
      if (io_ready) begin
        obs_lat = cyc; obs_data = io_read_data; obs_err = bus_err; obs_cnt = err_cnt;
        break;
      end
      ack_manual = (cyc == ack_at) ? mask : '0;
      if (cyc == poke_at) begin
        io_address = 32'hC000_0040; io_addr_strobe = 1'b1; io_write_strobe = 1'b1;
      end else begin
        {io_addr_strobe, io_read_strobe, io_write_strobe} = '0;
      end
      @(negedge clk);
    end
    ack_manual = '0; ack_follow = 1'b0;
    {io_addr_strobe, io_read_strobe, io_write_strobe} = '0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({io_ready, io_read_data, sys_cs, sys_rd, sys_wr, sys_addr, sys_be, sys_wr_data, bus_err, err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b rdata=%h cs=%b rd=%b wr=%b addr=%h be=%h wdata=%h err=%b cnt=%0d, want all 0",
               io_ready, io_read_data, sys_cs, sys_rd, sys_wr, sys_addr, sys_be, sys_wr_data, bus_err, err_cnt);
    end
    reset_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_write_zero_wait;
    sb.push_back('{data: 32'h0, err: 1'b0, lat: 2});
    issue(32'hC000_0010, 4'b0011, 32'h1234_5678, 1'b0, 1'b1, 0, 2'b01, 32'h0, -1);
    n_tests++;
    if ({obs_cs1, obs_wr1, obs_rd1, obs_addr1, obs_be1, obs_wdata1} !==
        {2'b01, 1'b1, 1'b0, ADDR_W'(4), 4'b0011, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL wr_cycle1: cs=%b wr=%b rd=%b addr=%h be=%b wdata=%h, want cs=01 wr=1 rd=0 addr=4 be=0011 wdata=12345678",
               obs_cs1, obs_wr1, obs_rd1, obs_addr1, obs_be1, obs_wdata1);
    end
    e = sb.pop_front();
    n_tests++;
    if (obs_lat !== e.lat || obs_data !== e.data || obs_err !== e.err) begin
      n_fail++;
      $display("FAIL wr_resp: lat=%0d data=%h err=%b, want lat=%0d data=%h err=%b", obs_lat, obs_data, obs_err, e.lat, e.data, e.err);
    end
  endtask

  task automatic test_read_late_ack;
    sb.push_back('{data: 32'hA5A5_0001, err: 1'b0, lat: 5});
    issue(32'hC040_0008, 4'b1111, 32'h0, 1'b1, 1'b0, 4, 2'b10, 32'hA5A5_0001, -1);
    n_tests++;
    if (obs_cs1 !== 2'b10 || obs_rd1 !== 1'b1 || obs_addr1 !== word_addr(32'hC040_0008) || obs_cs_cyc != 4) begin
      n_fail++;
      $display("FAIL rd_late_cs: cs=%b rd=%b addr=%h cs_cycles=%0d, want cs=10 rd=1 addr=%h cs_cycles=4",
               obs_cs1, obs_rd1, obs_addr1, obs_cs_cyc, word_addr(32'hC040_0008));
    end
    e = sb.pop_front();
    n_tests++;
    if (obs_lat !== e.lat || obs_data !== e.data || obs_err !== e.err) begin
      n_fail++;
      $display("FAIL rd_late_resp: lat=%0d data=%h err=%b, want lat=%0d data=%h err=%b", obs_lat, obs_data, obs_err, e.lat, e.data, e.err);
    end
  endtask

  task automatic test_both_strobes;
    sb.push_back('{data: 32'h0, err: 1'b0, lat: 2});
    issue(32'hC040_0020, 4'b1000, 32'hCAFE_0002, 1'b1, 1'b1, 0, 2'b10, 32'h1111_2222, -1);
    n_tests++;
    if (obs_wr1 !== 1'b1 || obs_rd1 !== 1'b0 || obs_cs1 !== 2'b10) begin
      n_fail++;
      $display("FAIL both_strobes_op: wr=%b rd=%b cs=%b, want wr=1 rd=0 cs=10", obs_wr1, obs_rd1, obs_cs1);
    end
    e = sb.pop_front();
    n_tests++;
    if (obs_lat !== e.lat || obs_data !== e.data || obs_err !== e.err) begin
      n_fail++;
      $display("FAIL both_strobes_resp: lat=%0d data=%h err=%b, want lat=%0d data=%h err=%b", obs_lat, obs_data, obs_err, e.lat, e.data, e.err);
    end
  endtask

  task automatic test_decode_miss;
    logic [31:0] addrs [3];
    logic        wrs   [3];
    addrs = '{32'h8000_0000, 32'hC0C0_0000, 32'h1000_0004};
    wrs   = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      exp_cnt = bump(exp_cnt);
      sb.push_back('{data: wrs[i] ? 32'h0 : ERR_DATA, err: 1'b1, lat: 1});
      issue(addrs[i], 4'hF, 32'h5555_AAAA, !wrs[i], wrs[i], 0, 2'b11, 32'h7777_0000, -1);
      e = sb.pop_front();
      n_tests++;
      if (obs_lat !== e.lat || obs_data !== e.data || obs_err !== e.err || obs_cs_cyc != 0 || obs_wr_cyc != 0 || obs_cnt !== 8'(exp_cnt)) begin
        n_fail++;
        $display("FAIL miss_%0d: lat=%0d data=%h err=%b cs_cycles=%0d wr_cycles=%0d cnt=%0d, want lat=%0d data=%h err=%b cs_cycles=0 wr_cycles=0 cnt=%0d",
                 i, obs_lat, obs_data, obs_err, obs_cs_cyc, obs_wr_cyc, obs_cnt, e.lat, e.data, e.err, exp_cnt);
      end
    end
  endtask

  task automatic test_timeout;
    // No ack, ack exactly in the last ACCESS cycle, and an ack from the wrong slot.
    int          ack_at [3];
    logic [1:0]  mask   [3];
    logic        is_err [3];
    ack_at = '{-1, int'(TIMEOUT_CYC), 2};
    mask   = '{2'b01, 2'b01, 2'b10};
    is_err = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      if (is_err[i]) exp_cnt = bump(exp_cnt);
      sb.push_back('{data: is_err[i] ? ERR_DATA : 32'h600D_0064, err: is_err[i], lat: int'(TIMEOUT_CYC) + 1});
      issue(32'hC000_0100, 4'hF, 32'h0, 1'b1, 1'b0, ack_at[i], mask[i], 32'h600D_0064, -1);
      e = sb.pop_front();
      n_tests++;
      if (obs_lat !== e.lat || obs_data !== e.data || obs_err !== e.err || obs_cs_cyc != int'(TIMEOUT_CYC) || obs_cnt !== 8'(exp_cnt)) begin
        n_fail++;
        $display("FAIL timeout_%0d: lat=%0d data=%h err=%b cs_cycles=%0d cnt=%0d, want lat=%0d data=%h err=%b cs_cycles=%0d cnt=%0d",
                 i, obs_lat, obs_data, obs_err, obs_cs_cyc, obs_cnt, e.lat, e.data, e.err, TIMEOUT_CYC, exp_cnt);
      end
    end
  endtask

  task automatic test_strobe_ignored;
    int stray;
    sb.push_back('{data: 32'h3C3C_0003, err: 1'b0, lat: 4});
    issue(32'hC040_0030, 4'hF, 32'h0, 1'b1, 1'b0, 3, 2'b10, 32'h3C3C_0003, 2);
    e = sb.pop_front();
    n_tests++;
    if (obs_lat !== e.lat || obs_data !== e.data || obs_err !== e.err || obs_wr_cyc != 0) begin
      n_fail++;
      $display("FAIL busy_strobe_resp: lat=%0d data=%h err=%b wr_cycles=%0d, want lat=%0d data=%h err=%b wr_cycles=0",
               obs_lat, obs_data, obs_err, obs_wr_cyc, e.lat, e.data, e.err);
    end
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (sys_cs != '0 || io_ready) stray++;
    end
    n_tests++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL busy_strobe_stray: active_cycles=%0d, want 0", stray);
    end
  endtask

  task automatic test_back_to_back;
    time t0, t1;
    sb.push_back('{data: 32'hB2B2_0000, err: 1'b0, lat: 2});
    sb.push_back('{data: 32'hB2B2_0001, err: 1'b0, lat: 2});
    issue(32'hC000_0004, 4'hF, 32'h0, 1'b1, 1'b0, 0, 2'b01, 32'hB2B2_0000, -1);
    t0 = $time;
    e = sb.pop_front();
    n_tests++;
    if (obs_lat !== e.lat || obs_data !== e.data || obs_err !== e.err) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d data=%h err=%b, want lat=%0d data=%h err=%b", obs_lat, obs_data, obs_err, e.lat, e.data, e.err);
    end
    issue(32'hC040_0004, 4'hF, 32'h0, 1'b1, 1'b0, 0, 2'b10, 32'hB2B2_0001, -1);
    t1 = $time;
    e = sb.pop_front();
    n_tests++;
    if (obs_lat !== e.lat || obs_data !== e.data || obs_err !== e.err || (t1 - t0) != 30) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d data=%h err=%b period=%0t, want lat=%0d data=%h err=%b period=30",
               obs_lat, obs_data, obs_err, t1 - t0, e.lat, e.data, e.err);
    end
  endtask

  task automatic test_err_saturation;
    for (int i = 0; i < 300; i++) begin
      exp_cnt = bump(exp_cnt);
      sb.push_back('{data: ERR_DATA, err: 1'b1, lat: 1});
      issue(32'h0000_0000, 4'hF, 32'h0, 1'b1, 1'b0, -1, 2'b00, 32'h0, -1);
      e = sb.pop_front();
      n_tests++;
      if (obs_lat !== e.lat || obs_err !== e.err || obs_data !== e.data || obs_cnt !== 8'(exp_cnt)) begin
        n_fail++;
        $display("FAIL sat_%0d: lat=%0d err=%b data=%h cnt=%0d, want lat=%0d err=1 data=%h cnt=%0d",
                 i, obs_lat, obs_err, obs_data, obs_cnt, e.lat, e.data, exp_cnt);
      end
    end
    @(negedge clk);
    n_tests++;
    if (err_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_final: cnt=%0d, want 255", err_cnt);
    end
  endtask

  task automatic test_reset_mid_access;
    int spurious;
    @(negedge clk);
    io_address = 32'hC040_0044; io_byte_enable = 4'hF; io_write_data = 32'h0;
    io_addr_strobe = 1'b1; io_read_strobe = 1'b1;
    @(negedge clk);
    {io_addr_strobe, io_read_strobe, io_write_strobe} = '0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (sys_cs !== 2'b10 || sys_rd !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: cs=%b rd=%b, want cs=10 rd=1", sys_cs, sys_rd);
    end
    #1 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({io_ready, io_read_data, sys_cs, sys_rd, sys_wr, sys_addr, sys_be, sys_wr_data, bus_err, err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_async: ready=%b cs=%b rd=%b wr=%b addr=%h be=%h cnt=%0d, want all 0",
               io_ready, sys_cs, sys_rd, sys_wr, sys_addr, sys_be, err_cnt);
    end
    exp_cnt = 0;
    spurious = 0;
    repeat (2) begin
      @(negedge clk);
      if (io_ready) spurious++;
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (io_ready || sys_cs != '0) spurious++;
    end
    n_tests++;
    if (spurious != 0) begin
      n_fail++;
      $display("FAIL rst_mid_no_ready: spurious_cycles=%0d, want 0", spurious);
    end
    sb.push_back('{data: 32'h0BAD_F00D, err: 1'b0, lat: 2});
    issue(32'hC040_0048, 4'hF, 32'h0, 1'b1, 1'b0, 0, 2'b10, 32'h0BAD_F00D, -1);
    e = sb.pop_front();
    n_tests++;
    if (obs_lat !== e.lat || obs_data !== e.data || obs_err !== e.err || obs_cnt !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL rst_mid_after: lat=%0d data=%h err=%b cnt=%0d, want lat=%0d data=%h err=%b cnt=0",
               obs_lat, obs_data, obs_err, obs_cnt, e.lat, e.data, e.err);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    {io_addr_strobe, io_read_strobe, io_write_strobe} = '0;
    io_address = '0; io_byte_enable = '0; io_write_data = '0;
    sys_rd_data = '0; ack_manual = '0; ack_follow = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_late_ack();
    test_both_strobes();
    test_decode_miss();
    test_timeout();
    test_strobe_ignored();
    test_back_to_back();
    test_err_saturation();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
